// File: rtl/bi_gray_if.sv
// ---------------------------------------------------------------------------
// bi_gray_if: request/result bundle for the bi_gray code converter.
//   b         : input word (binary when mode=0, Gray when mode=1)
//   in_valid  : qualifies b/mode on the rising clock edge
//   mode      : 0 = binary-to-Gray, 1 = Gray-to-binary
//   g         : registered converted word
//   out_valid : high for the cycle after an accepted input
//   par       : registered Gray-domain parity (only with BI_GRAY_PARITY_EN)
// Modports: master drives the request and samples the result; slave is the
// converter.
// ---------------------------------------------------------------------------
interface bi_gray_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] b;
  logic             in_valid;
  logic             mode;
  logic [WIDTH-1:0] g;
  logic             out_valid;
`ifdef BI_GRAY_PARITY_EN
  logic             par;

  modport master (output b, output in_valid, output mode,
                  input  g, input  out_valid, input par);
  modport slave  (input  b, input  in_valid, input  mode,
                  output g, output out_valid, output par);
`else
  modport master (output b, output in_valid, output mode,
                  input  g, input  out_valid);
  modport slave  (input  b, input  in_valid, input  mode,
                  output g, output out_valid);
`endif
endinterface

// File: rtl/bi_gray.sv
// ---------------------------------------------------------------------------
// bi_gray: registered binary<->Gray converter, one word per clock, one cycle
// of latency.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears g, out_valid, par)
//   bus   : bi_gray_if.slave (b, in_valid, mode in; g, out_valid[, par] out)
// Optional feature macro: BI_GRAY_PARITY_EN adds the registered par output,
// the XOR-reduction of the Gray-domain word.
// Parameter WIDTH: word width, legal range 2..32.
// ---------------------------------------------------------------------------
module bi_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  bi_gray_if.slave  bus
);

  localparam int unsigned W = WIDTH;

  logic [W-1:0] conv_c;
  logic [W-1:0] g_d,  g_q;
  logic         vld_d, vld_q;

  // Combinational conversion of the presented word.
  // Gray-to-binary bit i is the XOR of all Gray bits from the MSB down to i,
  // written as a reduction of a shifted word so there is no ripple feedback.
  always_comb begin
    conv_c = '0;
    if (bus.mode) begin
      for (int unsigned i = 0; i < W; i++) begin
        conv_c[i] = ^(bus.b >> i);
      end
    end else begin
      conv_c = bus.b ^ (bus.b >> 1);
    end
  end

  // Next-state: load on accept, otherwise hold g and drop valid.
  always_comb begin
    g_d   = g_q;
    vld_d = 1'b0;
    if (bus.in_valid) begin
      g_d   = conv_c;
      vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      g_q   <= g_d;
      vld_q <= vld_d;
    end
  end

  assign bus.g         = g_q;
  assign bus.out_valid = vld_q;

`ifdef BI_GRAY_PARITY_EN
  logic par_c;
  logic par_d, par_q;

  // Gray-domain parity: in mode 0 the parity of the Gray output collapses
  // to b[0]; in mode 1 the Gray word is the input itself.
  always_comb begin
    par_c = bus.mode ? (^bus.b) : bus.b[0];
    par_d = par_q;
    if (bus.in_valid) begin
      par_d = par_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end

  assign bus.par = par_q;
`endif

endmodule

// File: tb/tb_bi_gray.sv
// ---------------------------------------------------------------------------
// tb_bi_gray: self-checking bench for bi_gray (WIDTH=4). Directed vectors,
// hold, round-trip sweep, async reset and a randomized run, all checked
// against a reference model kept here.
// ---------------------------------------------------------------------------
module tb_bi_gray;

  localparam int unsigned W = 4;
  localparam int unsigned N = 1 << W;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  bi_gray_if #(.WIDTH(W)) bus ();

  bi_gray #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  // Reference model state
  logic [W-1:0] exp_g;
  logic         exp_v;
`ifdef BI_GRAY_PARITY_EN
  logic         exp_par;
`endif

  // Binary-to-Gray straight from the per-bit definition.
  function automatic logic [W-1:0] m_b2g(input logic [W-1:0] x);
    logic [W-1:0] r;
    r[W-1] = x[W-1];
    for (int i = W - 2; i >= 0; i--) r[i] = x[i+1] ^ x[i];
    return r;
  endfunction

  // Gray-to-binary as the inverse mapping: search the binary value whose
  // Gray code matches.
  function automatic logic [W-1:0] m_g2b(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int n = 0; n < int'(N); n++) begin
      if (m_b2g(W'(n)) == x) r = W'(n);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".g"},         32'(bus.g),         32'(exp_g));
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_v));
`ifdef BI_GRAY_PARITY_EN
    check({tag, ".par"},       32'(bus.par),       32'(exp_par));
`endif
  endtask

  // Present one word at the falling edge, sample #1 after the next rising
  // edge, and advance the model.
  task automatic step(input logic v, input logic m, input logic [W-1:0] x);
    @(negedge clk);
    bus.in_valid = v;
    bus.mode     = m;
    bus.b        = x;
    @(posedge clk);
    #1;
    if (v) begin
      exp_g = m ? m_g2b(x) : m_b2g(x);
      exp_v = 1'b1;
`ifdef BI_GRAY_PARITY_EN
      exp_par = 1'($countones(m ? x : m_b2g(x)) & 1);
`endif
    end else begin
      exp_v = 1'b0;
    end
  endtask

  task automatic model_reset();
    exp_g = '0;
    exp_v = 1'b0;
`ifdef BI_GRAY_PARITY_EN
    exp_par = 1'b0;
`endif
  endtask

  logic [W-1:0] gray_tab [N];
  logic [W-1:0] held_g;

  initial begin
    bus.in_valid = 1'b0;
    bus.mode     = 1'b0;
    bus.b        = '0;
    rst_n        = 1'b0;
    model_reset();

    // Reset state before any clock edge
    #2;
    check("reset_initial", 32'(bus.g), 32'd0);
    check("reset_initial_vld", 32'(bus.out_valid), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_model("post_release_idle");

    // Directed binary-to-Gray, back-to-back
    step(1'b1, 1'b0, 4'b1000); check_model("b2g_1000"); check("b2g_1000_lit", 32'(bus.g), 32'b1100);
    step(1'b1, 1'b0, 4'b0110); check_model("b2g_0110"); check("b2g_0110_lit", 32'(bus.g), 32'b0101);
    step(1'b1, 1'b0, 4'b0101); check_model("b2g_0101"); check("b2g_0101_lit", 32'(bus.g), 32'b0111);
    step(1'b1, 1'b0, 4'b0001); check_model("b2g_0001"); check("b2g_0001_lit", 32'(bus.g), 32'b0001);
`ifdef BI_GRAY_PARITY_EN
    check("b2g_0001_par_lit", 32'(bus.par), 32'd1);
`endif

    // Directed Gray-to-binary, mode switch with no bubble
    step(1'b1, 1'b1, 4'b1100); check_model("g2b_1100"); check("g2b_1100_lit", 32'(bus.g), 32'b1000);
    step(1'b1, 1'b1, 4'b0101); check_model("g2b_0101"); check("g2b_0101_lit", 32'(bus.g), 32'b0110);
    step(1'b1, 1'b1, 4'b1000); check_model("g2b_1000"); check("g2b_1000_lit", 32'(bus.g), 32'b1111);
    step(1'b1, 1'b0, 4'b1111); check_model("b2g_1111"); check("b2g_1111_lit", 32'(bus.g), 32'b1000);
    step(1'b1, 1'b1, 4'b0000); check_model("g2b_0000"); check("g2b_0000_lit", 32'(bus.g), 32'd0);

    // Hold: in_valid low with b changing (including unknowns)
    step(1'b1, 1'b0, 4'b1010);
    held_g = bus.g;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'($urandom), (k == 1) ? 4'bxxxx : W'($urandom));
      check_model("hold");
      check("hold_g_lit", 32'(bus.g), 32'(held_g));
    end

    // Round trip and single-bit adjacency
    for (int n = 0; n < int'(N); n++) begin
      step(1'b1, 1'b0, W'(n));
      check_model("sweep_b2g");
      gray_tab[n] = bus.g;
      step(1'b1, 1'b1, gray_tab[n]);
      check_model("sweep_g2b");
      check("roundtrip", 32'(bus.g), 32'(n));
    end
    for (int n = 0; n < int'(N); n++) begin
      check("gray_adjacent", 32'($countones(gray_tab[n] ^ gray_tab[(n + 1) % N])), 32'd1);
    end

    // Asynchronous reset mid-stream
    step(1'b1, 1'b0, 4'b0111);
    check_model("pre_reset");
    step(1'b1, 1'b0, 4'b1011);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async_reset");
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_model("release_no_valid");
    step(1'b1, 1'b0, 4'b0011);
    check_model("post_reset_first");
    check("post_reset_first_lit", 32'(bus.g), 32'b0010);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), W'($urandom));
      check_model("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
